// File: rtl/dev_icap.sv
// dev_icap: input-capture peripheral. Synchronizes and optionally deglitches a pin,
// pulses on qualified edges, and measures period / high time against a prescaled counter.
module dev_icap #(
   parameter int CNT_BITS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_in,
   output logic        io_risen,
   output logic        io_fallen,
   output logic        int_capture,
   output logic        int_ovf,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] dtw,
   output logic [31:0] dtr,
   input  logic        stb,
   output logic        ack
);

   typedef enum logic [1:0] {WAIT, HIGH, LOW} state_t;

   state_t              state_q;
   logic [6:0]          cfg_q;
   logic                s1_q, s2_q, lvl_q, lvl_d;
   logic [1:0]          fc_q, fc_d;
   logic [9:0]          pre_q;
   logic [CNT_BITS-1:0] tcnt_q, start_q, htmp_q, period_q, high_q, span;
   logic [2:0]          status_q, statusSet, statusClr;

   logic [2:0] src;
   logic       filt, inv;
   logic [1:0] mode;
   logic       x, update, rise, fall, tick, active, startEdge, expire;
   logic       cfgWr, statWr, store, hiDone, timeoutSet;
   logic       unusedDtw;

   assign src       = cfg_q[2:0];
   assign filt      = cfg_q[3];
   assign mode      = cfg_q[5:4];
   assign inv       = cfg_q[6];
   assign unusedDtw = ^dtw[31:7];

   assign cfgWr  = we && stb && (addr == 2'd0);
   assign statWr = we && stb && (addr == 2'd3);
   assign x      = s2_q ^ inv;

   // Deglitch: a new level is accepted only after three consecutive differing samples.
   always_comb begin
      lvl_d = lvl_q;
      fc_d  = 2'd0;
      if (!filt) begin
         lvl_d = x;
      end else if (x != lvl_q) begin
         if (fc_q == 2'd2) lvl_d = x;
         else fc_d = fc_q + 2'd1;
      end
   end

   assign update = (lvl_d != lvl_q);
   assign rise   = x & ~lvl_q & update;
   assign fall   = ~x & lvl_q & update;

   always_comb begin
      tick = 1'b0;
      case (src)
         3'd1:    tick = 1'b1;
         3'd2:    tick = &pre_q[2:0];
         3'd3:    tick = &pre_q[5:0];
         3'd4:    tick = &pre_q[7:0];
         3'd5:    tick = &pre_q[9:0];
         default: tick = 1'b0;
      endcase
   end

   assign active     = (mode != 2'd0) && (src != 3'd0) && (src < 3'd6);
   assign startEdge  = (mode == 2'd2) ? fall : rise;
   assign span       = tcnt_q - start_q;
   assign expire     = tick && (span == '1);
   assign store      = !cfgWr && active && (state_q == LOW) && startEdge;
   assign hiDone     = !cfgWr && active && (state_q == HIGH) && fall;
   assign timeoutSet = !cfgWr && active && (state_q != WAIT) && expire && !(store || hiDone);
   assign statusSet  = {timeoutSet, store & status_q[0], store};
   assign statusClr  = statWr ? dtw[2:0] : 3'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         lvl_q     <= 1'b0;
         fc_q      <= 2'd0;
         io_risen  <= 1'b0;
         io_fallen <= 1'b0;
      end else begin
         s1_q <= io_in;
         s2_q <= s1_q;
         if (cfgWr) begin
            lvl_q     <= s2_q ^ dtw[6];
            fc_q      <= 2'd0;
            io_risen  <= 1'b0;
            io_fallen <= 1'b0;
         end else begin
            lvl_q     <= lvl_d;
            fc_q      <= fc_d;
            io_risen  <= rise;
            io_fallen <= fall;
         end
      end
   end

   // Measurement FSM; tcnt is sampled before its own increment on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= WAIT;
         cfg_q       <= 7'd0;
         pre_q       <= 10'd0;
         tcnt_q      <= '0;
         start_q     <= '0;
         htmp_q      <= '0;
         period_q    <= '0;
         high_q      <= '0;
         status_q    <= 3'd0;
         int_capture <= 1'b0;
         int_ovf     <= 1'b0;
      end else begin
         pre_q       <= pre_q + 10'd1;
         if (tick) tcnt_q <= tcnt_q + CNT_BITS'(1);
         int_capture <= store;
         int_ovf     <= timeoutSet;
         status_q    <= (status_q & ~statusClr) | statusSet;
         if (cfgWr) begin
            cfg_q   <= dtw[6:0];
            pre_q   <= 10'd0;
            tcnt_q  <= '0;
            state_q <= WAIT;
         end else if (!active) begin
            state_q <= WAIT;
         end else begin
            case (state_q)
               WAIT: if (startEdge) begin
                  start_q <= tcnt_q;
                  state_q <= (mode == 2'd3) ? HIGH : LOW;
               end
               HIGH: if (fall) begin
                  htmp_q  <= span;
                  state_q <= LOW;
               end else if (expire) begin
                  state_q <= WAIT;
               end
               LOW: if (startEdge) begin
                  period_q <= span;
                  start_q  <= tcnt_q;
                  if (mode == 2'd3) begin
                     high_q  <= htmp_q;
                     state_q <= HIGH;
                  end
               end else if (expire) begin
                  state_q <= WAIT;
               end
               default: state_q <= WAIT;
            endcase
         end
      end
   end

   always_comb begin
      dtr = 32'd0;
      case (addr)
         2'd0:    dtr = {25'd0, cfg_q};
         2'd1:    dtr = 32'(period_q);
         2'd2:    dtr = 32'(high_q);
         default: dtr = {29'd0, status_q};
      endcase
   end

   assign ack = 1'b1;

endmodule

// File: tb/tb_dev_icap.sv
// Scoreboard bench for dev_icap: stimulus pushes expected edge pulses, captures and
// timeouts into queues; a monitor pops and compares whenever the DUT pulses.
module tb_dev_icap;

   logic        clk = 1'b0;
   logic        reset, io_in, io_risen, io_fallen, int_capture, int_ovf;
   logic        we, stb, ack;
   logic [1:0]  addr;
   logic [31:0] dtw, dtr;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      bit rise;
      int at;
   } edge_t;

   edge_t edgeQ[$];
   int    capQ[$];
   int    ovfQ[$];

   // Reference state: raw pin, filtered level and the expected status/high registers.
   bit pin      = 1'b0;
   bit fLevel   = 1'b0;
   bit expValid = 1'b0;
   bit expOvr   = 1'b0;
   bit expTo    = 1'b0;
   int expHigh  = 0;

   dev_icap #(.CNT_BITS(16)) dut (
      .clk(clk), .reset(reset), .io_in(io_in),
      .io_risen(io_risen), .io_fallen(io_fallen),
      .int_capture(int_capture), .int_ovf(int_ovf),
      .we(we), .addr(addr), .dtw(dtw), .dtr(dtr), .stb(stb), .ack(ack)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Compare one value and report mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bus write, issued on a negedge and landing on the following posedge.
   task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
      we = 1'b1; stb = 1'b1; addr = a; dtw = d;
      @(negedge clk);
      we = 1'b0; stb = 1'b0; addr = 2'd1; dtw = 32'd0;
   endtask

   task automatic readReg(input string name, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      checkOutput(name, dtr, exp);
      addr = 2'd1;
   endtask

   // Unfiltered pin drive: a change sampled next edge pulses three edges later.
   task automatic applyStimulus(input bit v, input int hold);
      if (v != pin) edgeQ.push_back('{rise: v, at: cyc + 3});
      io_in = v;
      pin   = v;
      fLevel = v;
      waitCycles(hold);
   endtask

   // Filtered pin drive: a new value held for at least three samples is accepted.
   task automatic filtSeg(input bit v, input int len);
      if (v != fLevel && len >= 3) begin
         edgeQ.push_back('{rise: v, at: cyc + 5});
         fLevel = v;
      end
      io_in = v;
      pin   = v;
      waitCycles(len);
   endtask

   // n rising edges h high / l low; every rise after the first completes a period.
   task automatic pwmRun(input int h, input int l, input int n, input int div, input bit isMode3);
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin
            capQ.push_back((h + l) / div);
            if (expValid) expOvr = 1'b1;
            expValid = 1'b1;
         end
         applyStimulus(1'b1, h);
         applyStimulus(1'b0, l);
      end
      if (isMode3) expHigh = h / div;
      readReg("period", 2'd1, 32'((h + l) / div));
      readReg("high", 2'd2, 32'(expHigh));
      readReg("status", 2'd3, 32'({expTo, expOvr, expValid}));
   endtask

   task automatic clearStatus();
      busWrite(2'd3, 32'd7);
      expValid = 1'b0; expOvr = 1'b0; expTo = 1'b0;
      readReg("statusCleared", 2'd3, 32'd0);
   endtask

   // Monitor: pops the matching queue whenever the DUT raises a pulse.
   initial begin
      edge_t e;
      int    v;
      forever begin
         @(negedge clk);
         #2;
         if (io_risen || io_fallen) begin
            if (edgeQ.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL edgeUnexpected: got rise=%0b fall=%0b at cycle %0d, required none", io_risen, io_fallen, cyc);
            end else begin
               e = edgeQ.pop_front();
               checkOutput("edgeRise", {31'd0, io_risen}, {31'd0, e.rise});
               checkOutput("edgeCycle", cyc, e.at);
            end
         end
         if (int_capture) begin
            if (capQ.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL captureUnexpected: got int_capture at cycle %0d, required none", cyc);
            end else begin
               v = capQ.pop_front();
               checkOutput("capturePeriod", dtr, 32'(v));
            end
         end
         if (int_ovf) begin
            if (ovfQ.size() == 0) begin
               checks++; failures++;
               $display("[TB] FAIL ovfUnexpected: got int_ovf at cycle %0d, required none", cyc);
            end else begin
               v = ovfQ.pop_front();
               checkOutput("ovfCycle", cyc, v);
            end
         end
      end
   end

   initial begin
      bit v;
      int h, l;
      reset = 1'b1; io_in = 1'b0; we = 1'b0; stb = 1'b0; addr = 2'd1; dtw = 32'd0;
      waitCycles(3);

      // Reset state.
      checkOutput("rstRisen", {31'd0, io_risen}, 32'd0);
      checkOutput("rstFallen", {31'd0, io_fallen}, 32'd0);
      checkOutput("rstCapture", {31'd0, int_capture}, 32'd0);
      checkOutput("rstOvf", {31'd0, int_ovf}, 32'd0);
      checkOutput("ack", {31'd0, ack}, 32'd1);
      for (int a = 0; a < 4; a++) readReg("rstDtr", 2'(a), 32'd0);
      reset = 1'b0;
      waitCycles(4);

      // PWM at full rate: one capture after the second rise.
      $display("[TB] PWM src=clk");
      busWrite(2'd0, 32'h31);
      readReg("cfg", 2'd0, 32'h31);
      pwmRun(30, 70, 2, 1, 1'b1);

      // Prescaled by 8; overrun accumulates since valid stays set.
      $display("[TB] PWM src=/8");
      busWrite(2'd0, 32'h32);
      pwmRun(80, 160, 3, 8, 1'b1);

      // Random PWM shapes.
      for (int i = 0; i < 4; i++) begin
         h = $urandom_range(5, 60);
         l = $urandom_range(5, 60);
         busWrite(2'd0, 32'h31);
         pwmRun(h, l, 3, 1, 1'b1);
      end

      // Deglitch filter: 2-cycle glitch rejected, 3-cycle pulse accepted.
      $display("[TB] filter");
      fLevel = pin;
      busWrite(2'd0, 32'h39);
      waitCycles(3);
      filtSeg(1'b1, 2);
      filtSeg(1'b0, 10);
      filtSeg(1'b1, 3);
      filtSeg(1'b0, 10);
      busWrite(2'd0, 32'h08);
      v = pin;
      for (int i = 0; i < 14; i++) begin
         v = !v;
         filtSeg(v, $urandom_range(1, 5));
      end
      filtSeg(!v, 8);
      if (pin) filtSeg(1'b0, 8);

      // Rise-to-rise period with overrun, then W1C.
      $display("[TB] mode 1 overrun");
      clearStatus();
      busWrite(2'd0, 32'h11);
      pwmRun(25, 25, 4, 1, 1'b0);
      busWrite(2'd3, 32'd3);
      expValid = 1'b0; expOvr = 1'b0;
      readReg("statusW1C", 2'd3, 32'd0);

      // Timeout after 2^16-1 ticks with the pin held high.
      $display("[TB] timeout");
      busWrite(2'd0, 32'h31);
      ovfQ.push_back(cyc + 3 + 65535);
      applyStimulus(1'b1, 65535 + 10);
      expTo = 1'b1;
      readReg("statusTimeout", 2'd3, 32'd4);
      applyStimulus(1'b0, 10);
      applyStimulus(1'b1, 20);
      readReg("statusRestart", 2'd3, 32'd4);

      // Reset in HIGH state, pin still high at release.
      $display("[TB] reset mid-measurement");
      reset = 1'b1;
      waitCycles(2);
      checkOutput("midRstRisen", {31'd0, io_risen}, 32'd0);
      checkOutput("midRstCapture", {31'd0, int_capture}, 32'd0);
      for (int a = 0; a < 4; a++) readReg("midRstDtr", 2'(a), 32'd0);
      reset = 1'b0;
      edgeQ.push_back('{rise: 1'b1, at: cyc + 3});
      waitCycles(8);
      readReg("postRstPeriod", 2'd1, 32'd0);
      readReg("postRstHigh", 2'd2, 32'd0);

      waitCycles(5);
      checkOutput("edgeQEmpty", 32'(edgeQ.size()), 32'd0);
      checkOutput("capQEmpty", 32'(capQ.size()), 32'd0);
      checkOutput("ovfQEmpty", 32'(ovfQ.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
